boot_rom_bridge: RTL and testbench
==================================

Name: boot_rom_bridge

Overview:
- Request-side adapter directly upstream of the boot ROM macro.
- Converts the SoC interconnect req/gnt/r_valid protocol into the ROM's chip-select/word-address interface, which has 1-cycle read latency.
- Buffers read responses in a small FIFO so the interconnect can backpressure with r_ready.
- Returns an error response for writes, misaligned addresses and out-of-window addresses without touching the ROM.

Parameters:
- ROM_ADDR_WIDTH, 13, byte-address width of the ROM window (2^13 B = 8 KiB).
- ROM_BASE, 32'h1A00_0000, window base; only bits [31:ROM_ADDR_WIDTH] are compared.
- FIFO_DEPTH, 2, response FIFO entries; power of 2, minimum 2.
- ERR_RDATA, 32'hBADA_CCE5, rdata returned with an error response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- add_i  in  32  byte address
- we_i  in  1  write enable (a write is always an error)
- r_valid_o  out  1  response valid
- r_ready_i  in  1  response consumed
- r_rdata_o  out  32  response data
- r_opc_o  out  1  1 = error response
- rom_csn_o  out  1  ROM chip select, active low
- rom_add_o  out  ROM_ADDR_WIDTH-2  ROM word address
- rom_rdata_i  in  32  ROM data, valid 1 cycle after rom_csn_o low
- busy_o  out  1  FIFO non-empty or a ROM read is in flight

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO emptied, in-flight flag cleared.
  - gnt_o=0 and rom_csn_o=1 while rst_i is high; r_valid_o=0, r_opc_o=0, r_rdata_o=0, busy_o=0.
- Reset mid-operation: an in-flight ROM read is discarded and no response is produced for it.
- Occupancy: occ = fifo_count + inflight - pop, where pop = r_valid_o & r_ready_i.
- Grant: gnt_o = req_i & ~rst_i & (occ < FIFO_DEPTH). gnt_o depends combinationally on r_ready_i.
- Classification of an accepted request (req_i & gnt_o), in cycle T:
  - Good read: we_i=0, add_i[1:0]=0, add_i[31:ROM_ADDR_WIDTH]=ROM_BASE[31:ROM_ADDR_WIDTH].
  - Good read: rom_csn_o=0 in cycle T; rom_add_o=add_i[ROM_ADDR_WIDTH-1:2]; in-flight flag set.
  - Error (anything else): no ROM access; an error entry is marked in flight.
- rom_add_o always follows add_i[ROM_ADDR_WIDTH-1:2]; rom_csn_o=1 whenever no good read is granted.
- Capture, in cycle T+1:
  - Good read: rom_rdata_i is pushed into the FIFO with opc=0.
  - Error: ERR_RDATA is pushed with opc=1.
- Latency: r_valid_o first visible in cycle T+2. Throughput is 1 request/cycle when r_ready_i is held high.
- Ordering: strictly in-order; good and error responses share the same FIFO.
- FIFO outputs:
  - r_valid_o = FIFO non-empty; r_rdata_o and r_opc_o come from the head entry.
  - Head entry is stable while r_valid_o & ~r_ready_i.
- Full: the grant rule guarantees a push never occurs into a full FIFO. Push and pop in the same cycle are both honoured and count is unchanged.
- Empty: r_ready_i is ignored while r_valid_o=0.
- Pointers wrap modulo FIFO_DEPTH.
- busy_o = (fifo_count!=0) | inflight.

Optional Feature:
- Macro: BOOT_ROM_LOCK_EN.
- Defined:
  - Adds port lock_i, in, 1.
  - A sticky lock register is set on any cycle with lock_i=1 and cleared only by rst_i.
  - While the lock is set (and in the same cycle lock_i first rises), every request is classified as an error: rom_csn_o stays 1 and ERR_RDATA is returned with opc=1.
  - Requests granted before the lock keep their original classification.
- Not defined: no lock_i port, no lock register; behaviour exactly as above.

Test Plan:
- Reset, then read 0x1A00_0004 with the ROM model returning 0x1234_5678:
  - rom_csn_o=0 and rom_add_o=1 in cycle T.
  - r_valid_o=1, r_rdata_o=0x1234_5678, r_opc_o=0 at T+2.
- Back-to-back reads 0x1A00_0000..0x1A00_001C with r_ready_i=1: gnt_o=1 in every cycle; 8 responses in order on 8 consecutive cycles.
- r_ready_i=0 with 4 reads issued:
  - 2 granted, then gnt_o=0 while the FIFO is full.
  - Head data stable.
  - Raising r_ready_i resumes grants; all 4 responses arrive in order.
- Write to 0x1A00_0000, read 0x1A00_0002, read 0x1A10_0000: rom_csn_o stays 1; three responses, each r_opc_o=1, r_rdata_o=0xBADA_CCE5.
- Assert rst_i in the cycle after a read is granted: no response ever appears; r_valid_o=0, busy_o=0 after reset.
- With BOOT_ROM_LOCK_EN, pulse lock_i, then read 0x1A00_0000: rom_csn_o stays 1; error response returned; lock persists until rst_i.

Source files
------------

// File: rtl/boot_rom_bridge.sv
// Request adapter in front of the boot ROM: interconnect req/gnt/r_valid to ROM csn/word-address,
// with an in-order response FIFO. Optional sticky lock via `BOOT_ROM_LOCK_EN (adds lock_i).
module boot_rom_bridge #(
  parameter int          ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] ROM_BASE       = 32'h1A00_0000,
  parameter int          FIFO_DEPTH     = 2,
  parameter logic [31:0] ERR_RDATA      = 32'hBADA_CCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               add_i,
  input  logic                      we_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [31:0]               r_rdata_o,
  output logic                      r_opc_o,
  output logic                      rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0] rom_add_o,
  input  logic [31:0]               rom_rdata_i,
`ifdef BOOT_ROM_LOCK_EN
  input  logic                      lock_i,
`endif
  output logic                      busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic          r_mem_opc  [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_inflight;
  logic          r_inflight_err;

  logic          w_locked;
  logic          w_good;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_occ;

`ifdef BOOT_ROM_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_lock <= 1'b0;
    else if (lock_i) r_lock <= 1'b1;
  end

  // The rising cycle of lock_i already blocks ROM access.
  assign w_locked = r_lock | lock_i;
`else
  assign w_locked = 1'b0;
`endif

  assign w_good = ~we_i & (add_i[1:0] == 2'b00)
                & (add_i[31:ROM_ADDR_WIDTH] == ROM_BASE[31:ROM_ADDR_WIDTH])
                & ~w_locked;

  assign r_valid_o = (r_count != '0);
  assign w_pop     = r_valid_o & r_ready_i;
  assign w_push    = r_inflight & ~rst_i;

  // NOTE: the in-flight entry reserves a slot, and a same-cycle pop frees one, so gnt_o is
  // combinational on r_ready_i; this is what lets full-rate streaming work with a 2-entry FIFO.
  assign w_occ = r_count + CW'(r_inflight) - CW'(w_pop);
  assign gnt_o = req_i & ~rst_i & (w_occ < DEPTH_C);

  assign rom_csn_o = ~(gnt_o & w_good);
  assign rom_add_o = add_i[ROM_ADDR_WIDTH-1:2];

  assign r_rdata_o = r_valid_o ? r_mem_data[r_rptr] : '0;
  assign r_opc_o   = r_valid_o ? r_mem_opc[r_rptr]  : 1'b0;
  assign busy_o    = r_valid_o | r_inflight;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight     <= 1'b0;
      r_inflight_err <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
    end else begin
      r_inflight     <= gnt_o;
      r_inflight_err <= ~w_good;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the outputs are masked by r_valid_o, so stale
  // entries are never observable and the array can map to plain flops or a register file.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= r_inflight_err ? ERR_RDATA : rom_rdata_i;
      r_mem_opc[r_wptr]  <= r_inflight_err;
    end
  end

endmodule

// File: tb/tb_boot_rom_bridge.sv
// Bench for boot_rom_bridge: directed scenarios plus random traffic, checked every cycle
// against a queue-based response model and a behavioural ROM.
module tb_boot_rom_bridge;

  localparam int          AW    = 13;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h1A00_0000;
  localparam logic [31:0] ERR   = 32'hBADA_CCE5;
`ifdef BOOT_ROM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i, req_i, we_i, r_ready_i, lock_i;
  logic [31:0]   add_i, rom_rdata_i;
  logic          gnt_o, r_valid_o, r_opc_o, rom_csn_o, busy_o;
  logic [31:0]   r_rdata_o;
  logic [AW-3:0] rom_add_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  boot_rom_bridge #(.ROM_ADDR_WIDTH(AW), .ROM_BASE(BASE), .FIFO_DEPTH(DEPTH), .ERR_RDATA(ERR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .we_i(we_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .rom_csn_o(rom_csn_o), .rom_add_o(rom_add_o), .rom_rdata_i(rom_rdata_i),
`ifdef BOOT_ROM_LOCK_EN
    .lock_i(lock_i),
`endif
    .busy_o(busy_o)
  );

  // Behavioural ROM with one cycle of read latency.
  logic [31:0] rom_mem [1 << (AW-2)];
  always @(posedge clk_i) if (!rom_csn_o) rom_rdata_i <= rom_mem[rom_add_o];

  // Reference model: visible responses in a queue plus at most one entry in flight.
  typedef struct { logic [31:0] data; logic opc; } resp_t;
  resp_t       q[$];
  bit          infl = 1'b0;
  resp_t       infl_r;
  bit          lock_m = 1'b0;
  bit          mon_en = 1'b0;
  bit          s_rst = 1'b0, s_pop = 1'b0, s_gnt = 1'b0, s_good = 1'b0, s_lock = 1'b0;
  logic [31:0] s_addr = '0;
  bit          e_valid, e_pop, e_gnt, e_good, e_csn, e_busy;
  int          occ;

  always @(negedge clk_i) begin
    if (mon_en) begin
      e_valid = (q.size() != 0);
      e_pop   = e_valid && r_ready_i;
      occ     = q.size() + int'(infl) - int'(e_pop);
      e_gnt   = req_i && !rst_i && (occ < DEPTH);
      e_good  = !we_i && (add_i[1:0] == 2'b00) && (add_i[31:AW] == BASE[31:AW])
                && !(LOCK_EN && (lock_m || lock_i));
      e_csn   = !(e_gnt && e_good);
      e_busy  = e_valid || infl;
      n_cmp++; if (gnt_o !== e_gnt) begin n_bad++; $display("FAIL gnt_o t=%0t got %b exp %b", $time, gnt_o, e_gnt); end
      n_cmp++; if (rom_csn_o !== e_csn) begin n_bad++; $display("FAIL rom_csn_o t=%0t got %b exp %b", $time, rom_csn_o, e_csn); end
      n_cmp++; if (rom_add_o !== add_i[AW-1:2]) begin n_bad++; $display("FAIL rom_add_o t=%0t got %h exp %h", $time, rom_add_o, add_i[AW-1:2]); end
      n_cmp++; if (r_valid_o !== e_valid) begin n_bad++; $display("FAIL r_valid_o t=%0t got %b exp %b", $time, r_valid_o, e_valid); end
      n_cmp++; if (busy_o !== e_busy) begin n_bad++; $display("FAIL busy_o t=%0t got %b exp %b", $time, busy_o, e_busy); end
      if (e_valid) begin
        n_cmp++; if (r_rdata_o !== q[0].data) begin n_bad++; $display("FAIL r_rdata_o t=%0t got %h exp %h", $time, r_rdata_o, q[0].data); end
        n_cmp++; if (r_opc_o !== q[0].opc) begin n_bad++; $display("FAIL r_opc_o t=%0t got %b exp %b", $time, r_opc_o, q[0].opc); end
      end
      s_rst = rst_i; s_pop = e_pop; s_gnt = e_gnt; s_good = e_good; s_lock = lock_i; s_addr = add_i;
    end
  end

  always @(posedge clk_i) begin
    if (mon_en) begin
      if (s_rst) begin
        q.delete(); infl = 1'b0; lock_m = 1'b0;
      end else begin
        if (s_pop) void'(q.pop_front());
        if (infl) q.push_back(infl_r);
        infl        = s_gnt;
        infl_r.data = s_good ? rom_mem[s_addr[AW-1:2]] : ERR;
        infl_r.opc  = !s_good;
        if (s_lock) lock_m = 1'b1;
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs;
    req_i = 1'b0; we_i = 1'b0; add_i = '0; r_ready_i = 1'b1; lock_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; idle_inputs(); req_i = 1'b1; add_i = BASE;
    repeat (2) next_cycle();
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_gnt got %b exp 0", gnt_o); end
    n_cmp++; if (rom_csn_o !== 1'b1) begin n_bad++; $display("FAIL reset_csn got %b exp 1", rom_csn_o); end
    n_cmp++; if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", r_valid_o); end
    n_cmp++; if (r_rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", r_rdata_o); end
    n_cmp++; if (r_opc_o !== 1'b0) begin n_bad++; $display("FAIL reset_opc got %b exp 0", r_opc_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    next_cycle();
    mon_en = 1'b1;
    next_cycle();
    rst_i = 1'b0; req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read;
    rom_mem[1] = 32'h1234_5678;
    req_i = 1'b1; add_i = 32'h1A00_0004; we_i = 1'b0; r_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL single_gnt got %b exp 1", gnt_o); end
    n_cmp++; if (rom_csn_o !== 1'b0) begin n_bad++; $display("FAIL single_csn got %b exp 0", rom_csn_o); end
    n_cmp++; if (rom_add_o !== 11'd1) begin n_bad++; $display("FAIL single_add got %h exp 1", rom_add_o); end
    next_cycle(); req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %b exp 0", r_valid_o); end
    next_cycle();
    @(negedge clk_i);
    n_cmp++; if (r_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b exp 1", r_valid_o); end
    n_cmp++; if (r_rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL single_rdata got %h exp 12345678", r_rdata_o); end
    n_cmp++; if (r_opc_o !== 1'b0) begin n_bad++; $display("FAIL single_opc got %b exp 0", r_opc_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    r_ready_i = 1'b1; we_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_i = (c < 8); add_i = BASE + 32'(4 * (c % 8));
      @(negedge clk_i);
      if (c < 8) begin
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt c=%0d got %b exp 1", c, gnt_o); end
      end
      if (c >= 2) begin
        n_cmp++; if (r_valid_o !== 1'b1 || r_rdata_o !== rom_mem[c-2]) begin
          n_bad++; $display("FAIL b2b_resp c=%0d got v=%b %h exp v=1 %h", c, r_valid_o, r_rdata_o, rom_mem[c-2]);
        end
      end
      next_cycle();
    end
    req_i = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_backpressure;
    int k = 0, got = 0, early = 0;
    logic [31:0] head0 = '0;
    we_i = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      req_i = (k < 4); add_i = BASE + 32'h20 + 32'(4 * k); r_ready_i = (c >= 8);
      @(negedge clk_i);
      if (gnt_o && req_i) begin k++; if (c < 8) early++; end
      if (c == 3) head0 = r_rdata_o;
      if (c == 7) begin
        n_cmp++; if (early != 2) begin n_bad++; $display("FAIL bp_grants got %0d exp 2", early); end
        n_cmp++; if (r_valid_o !== 1'b1 || r_rdata_o !== head0 || r_rdata_o !== rom_mem[8]) begin
          n_bad++; $display("FAIL bp_head_stable got %h exp %h", r_rdata_o, rom_mem[8]);
        end
      end
      if (r_valid_o && r_ready_i) begin
        n_cmp++; if (r_rdata_o !== rom_mem[8+got]) begin n_bad++; $display("FAIL bp_order n=%0d got %h exp %h", got, r_rdata_o, rom_mem[8+got]); end
        got++;
      end
      next_cycle();
    end
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL bp_count got %0d exp 4", got); end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_errors;
    logic [31:0] addrs [3];
    int nerr = 0, nresp = 0;
    addrs[0] = BASE; addrs[1] = 32'h1A00_0002; addrs[2] = 32'h1A10_0000;
    r_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_i = (c < 3); we_i = (c == 0); add_i = (c < 3) ? addrs[c] : '0;
      @(negedge clk_i);
      n_cmp++; if (rom_csn_o !== 1'b1) begin n_bad++; $display("FAIL err_csn c=%0d got %b exp 1", c, rom_csn_o); end
      if (r_valid_o) begin
        nresp++;
        if (r_opc_o === 1'b1 && r_rdata_o === ERR) nerr++;
      end
      next_cycle();
    end
    n_cmp++; if (nresp != 3 || nerr != 3) begin n_bad++; $display("FAIL err_resps got %0d/%0d exp 3/3", nerr, nresp); end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    req_i = 1'b1; add_i = BASE + 32'h8; we_i = 1'b0; r_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt got %b exp 1", gnt_o); end
    next_cycle(); req_i = 1'b0; rst_i = 1'b1;
    next_cycle(); rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      n_cmp++; if (r_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid c=%0d got %b exp 0", c, r_valid_o); end
      next_cycle();
    end
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b exp 0", busy_o); end
    next_cycle();
  endtask

`ifdef BOOT_ROM_LOCK_EN
  task automatic test_lock;
    idle_inputs(); lock_i = 1'b1;
    next_cycle(); lock_i = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req_i = 1'b1; add_i = BASE + 32'(4 * n);
      @(negedge clk_i);
      n_cmp++; if (rom_csn_o !== 1'b1) begin n_bad++; $display("FAIL lock_csn n=%0d got %b exp 1", n, rom_csn_o); end
      next_cycle(); req_i = 1'b0;
      next_cycle();
      @(negedge clk_i);
      n_cmp++; if (r_valid_o !== 1'b1 || r_opc_o !== 1'b1 || r_rdata_o !== ERR) begin
        n_bad++; $display("FAIL lock_resp n=%0d got v=%b opc=%b %h exp v=1 opc=1 %h", n, r_valid_o, r_opc_o, r_rdata_o, ERR);
      end
      repeat (3) next_cycle();
    end
    rst_i = 1'b1; next_cycle(); rst_i = 1'b0;
    req_i = 1'b1; add_i = BASE + 32'h4;
    @(negedge clk_i);
    n_cmp++; if (rom_csn_o !== 1'b0) begin n_bad++; $display("FAIL unlock_csn got %b exp 0", rom_csn_o); end
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();
  endtask
`endif

  task automatic test_random;
    int sel;
    for (int c = 0; c < 500; c++) begin
      req_i = ($urandom_range(3) != 0);
      we_i  = ($urandom_range(7) == 0);
      sel   = int'($urandom_range(7));
      if (sel == 0)      add_i = $urandom;
      else if (sel == 1) add_i = BASE + 32'($urandom_range(8191));
      else               add_i = BASE + {19'd0, 11'($urandom_range(2047)), 2'b00};
      r_ready_i = ($urandom_range(2) != 0);
      @(negedge clk_i);
      next_cycle();
    end
    idle_inputs();
    repeat (6) next_cycle();
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0 || r_valid_o !== 1'b0) begin n_bad++; $display("FAIL rand_drain got busy=%b valid=%b exp 0/0", busy_o, r_valid_o); end
    next_cycle();
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << (AW-2)); i++) rom_mem[i] = $urandom;
    rom_rdata_i = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid();
`ifdef BOOT_ROM_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
